// File: rtl/compensation_weight_loader.sv
// Compensation weight loader: fetches one tile of 4-bit CPE weights from
// Compensation_Memory (farthest row first) and streams the words into the
// CPE columns over ROWS gap-free valid cycles.
module compensation_weight_loader #(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [4*COLS-1:0]     mem_rdata,
    output logic [4*COLS-1:0]     Compensation_Weight,
    output logic                  Compensation_Weight_out_valid,
    output logic                  busy,
    output logic                  done
);

    // Counter doubles as row index in READ and drain-cycle count in DRAIN.
    localparam int unsigned CntW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rd_dly_q;
    logic                  valid_q;
    logic [4*COLS-1:0]     weight_q;

    // Next-state and registered-output decode for the load sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_en_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StRead;
                    cnt_d       = CntW'(ROWS - 1);
                    base_d      = base_addr;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = base_addr + ADDR_WIDTH'(ROWS - 1);
                end
            end
            StRead: begin
                if (cnt_q == '0) begin
                    // Two drain cycles: memory read latency plus output register.
                    state_d = StDrain;
                    cnt_d   = CntW'(1);
                end else begin
                    cnt_d       = cnt_q - CntW'(1);
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = base_q + ADDR_WIDTH'(cnt_q) - ADDR_WIDTH'(1);
                end
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d == StRead) || (state_d == StDrain);
        done_d = (state_d == StDone);
    end

    // Control state and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            base_q      <= '0;
            mem_addr_q  <= '0;
            mem_rd_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_en_q <= mem_rd_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Data path: align valid with read data; zero the bus outside valid cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dly_q <= 1'b0;
            valid_q  <= 1'b0;
            weight_q <= '0;
        end else begin
            rd_dly_q <= mem_rd_en_q;
            valid_q  <= rd_dly_q;
            weight_q <= rd_dly_q ? mem_rdata : '0;
        end
    end

    assign mem_rd_en                     = mem_rd_en_q;
    assign mem_addr                      = mem_addr_q;
    assign Compensation_Weight           = weight_q;
    assign Compensation_Weight_out_valid = valid_q;
    assign busy                          = busy_q;
    assign done                          = done_q;

endmodule

// File: tb/tb_compensation_weight_loader.sv
// Scoreboard bench for compensation_weight_loader: a ROWS=4 instance checked
// through cycle-tagged address/weight queues, plus a ROWS=1 instance.
module tb_compensation_weight_loader;

    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start_b;
    logic [7:0] base_addr, base_b;
    logic       rd_en, rd_en_b;
    logic [7:0] addr, addr_b;
    logic [7:0] rdata, rdata_b;
    logic [7:0] weight, weight_b;
    logic       valid, valid_b;
    logic       busy, busy_b;
    logic       done, done_b;

    logic [7:0] mem [256];

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    exp_t       addr_q[$];
    exp_t       wt_q[$];
    logic [7:0] cpe [R];
    int         cyc = 0;
    int         c0;
    int         n_cmp = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory models; idle read data is non-zero on purpose.
    always @(posedge clk) rdata   <= rd_en   ? mem[addr]   : 8'hEE;
    always @(posedge clk) rdata_b <= rd_en_b ? mem[addr_b] : 8'hEE;

    compensation_weight_loader #(
        .ROWS      (R),
        .COLS      (2),
        .ADDR_WIDTH(8)
    ) u_dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .start                        (start),
        .base_addr                    (base_addr),
        .mem_rd_en                    (rd_en),
        .mem_addr                     (addr),
        .mem_rdata                    (rdata),
        .Compensation_Weight          (weight),
        .Compensation_Weight_out_valid(valid),
        .busy                         (busy),
        .done                         (done)
    );

    compensation_weight_loader #(
        .ROWS      (1),
        .COLS      (2),
        .ADDR_WIDTH(8)
    ) u_dut_r1 (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .start                        (start_b),
        .base_addr                    (base_b),
        .mem_rd_en                    (rd_en_b),
        .mem_addr                     (addr_b),
        .mem_rdata                    (rdata_b),
        .Compensation_Weight          (weight_b),
        .Compensation_Weight_out_valid(valid_b),
        .busy                         (busy_b),
        .done                         (done_b)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT presents a read or a valid word.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (addr_q.size() > 0 && addr_q[0].cyc < cyc) begin
                e = addr_q.pop_front();
                chk("rd_missing_cycle", cyc, e.cyc);
            end
            while (wt_q.size() > 0 && wt_q[0].cyc < cyc) begin
                e = wt_q.pop_front();
                chk("valid_missing_cycle", cyc, e.cyc);
            end
            if (rd_en) begin
                if (addr_q.size() == 0) begin
                    chk("rd_en_unexpected", rd_en, 0);
                end else begin
                    e = addr_q.pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    chk("mem_addr", addr, e.val);
                end
            end
            if (valid) begin
                if (wt_q.size() == 0) begin
                    chk("valid_unexpected", valid, 0);
                end else begin
                    e = wt_q.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("weight", weight, e.val);
                end
                for (int d = R - 1; d > 0; d--) cpe[d] = cpe[d - 1];
                cpe[0] = weight;
            end else begin
                chk("weight_zero_when_invalid", weight, 0);
            end
        end
    end

    // Present start this cycle and queue the expected reads and weights.
    task automatic issue(input logic [7:0] b);
        logic [7:0] a;
        base_addr = b;
        start     = 1'b1;
        c0        = cyc;
        for (int i = 0; i < R; i++) begin
            a = b + 8'(R - 1 - i);
            addr_q.push_back('{cyc: c0 + 1 + i, val: a});
            wt_q.push_back('{cyc: c0 + 3 + i, val: mem[a]});
        end
    endtask

    // Full load; e1/e2 are cycle offsets at which start is re-pulsed (0 = none).
    task automatic run_load(input logic [7:0] b, input int e1, input int e2);
        logic [7:0] a;
        issue(b);
        for (int k = 1; k <= R + 4; k++) begin
            @(negedge clk);
            chk("busy", busy, (k <= R + 2));
            chk("done", done, (k == R + 3));
            start = (k == e1) || (k == e2);
        end
        start = 1'b0;
        for (int r = 0; r < R; r++) begin
            a = b + 8'(r);
            chk("cpe_row", cpe[r], mem[a]);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        start_b   = 1'b0;
        base_addr = 8'h00;
        base_b    = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h10] = 8'h21; mem[8'h11] = 8'h43; mem[8'h12] = 8'h65; mem[8'h13] = 8'h87;
        mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hB2; mem[8'h00] = 8'hC3; mem[8'h01] = 8'hD4;
        mem[8'h20] = 8'h1F; mem[8'h21] = 8'h2E; mem[8'h22] = 8'h3D; mem[8'h23] = 8'h4C;
        mem[8'h05] = 8'h9A;
        for (int d = 0; d < R; d++) cpe[d] = 8'h00;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {rd_en, addr, weight, valid, busy, done}, 0);
        chk("reset_outputs_r1", {rd_en_b, addr_b, weight_b, valid_b, busy_b, done_b}, 0);
        rst_n = 1'b1;

        repeat (20) begin
            @(negedge clk);
            chk("idle_outputs", {rd_en, addr, weight, valid, busy, done}, 0);
        end

        run_load(8'h10, 0, 0);
        run_load(8'hFE, 0, 0);
        // Re-pulses mid-load and in the DONE cycle are ignored; next one is taken.
        run_load(8'h10, 2, 7);
        run_load(8'hFE, 0, 0);

        // Asynchronous reset in the middle of READ.
        issue(8'h20);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_read_rd_en", rd_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {rd_en, addr, weight, valid, busy, done}, 0);
        addr_q.delete();
        wt_q.delete();
        @(negedge clk);
        chk("held_reset_outputs", {rd_en, addr, weight, valid, busy, done}, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        run_load(8'h20, 0, 0);

        // ROWS=1 instance: one read, one valid cycle, done three cycles after the read.
        base_b  = 8'h05;
        start_b = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start_b = 1'b0;
            chk("r1_rd_en", rd_en_b, (k == 1));
            if (k == 1) chk("r1_addr", addr_b, 8'h05);
            chk("r1_valid", valid_b, (k == 3));
            chk("r1_weight", weight_b, (k == 3) ? 8'h9A : 8'h00);
            chk("r1_busy", busy_b, (k <= 3));
            chk("r1_done", done_b, (k == 4));
        end

        repeat (4) @(negedge clk);
        chk("addr_queue_drained", addr_q.size(), 0);
        chk("weight_queue_drained", wt_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
